// File: rtl/cpu_defs_pkg.sv
// Shared CPU definitions: divider state encoding, iteration count and the
// hi/lo bypass bus layout used by the ex/mem/wb to-ID forwarding buses.
package cpu_defs_pkg;

  localparam int DIV_CYCLES = 32;
  localparam int HILO_W     = 32;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RUN    = 2'd1,
    ZERO   = 2'd2,
    FINISH = 2'd3
  } div_state_e;

  // {hi_we, lo_we, hi, lo} -- 66 bits
  typedef struct packed {
    logic              hi_we;
    logic              lo_we;
    logic [HILO_W-1:0] hi;
    logic [HILO_W-1:0] lo;
  } hilo_bus_t;

  function automatic logic [HILO_W-1:0] neg_if(input logic neg, input logic [HILO_W-1:0] v);
    return neg ? (~v + HILO_W'(1)) : v;
  endfunction

endpackage

// File: rtl/div_hilo_seq_div_step.sv
// One restoring-division iteration: shift {rem,quo} left and subtract the
// divisor if the shifted partial remainder covers it.
module div_step #(
  parameter int DW = 32
) (
  input  logic [DW-1:0] rem,
  input  logic [DW-1:0] quo,
  input  logic [DW-1:0] divisor,
  output logic [DW-1:0] rem_nx,
  output logic [DW-1:0] quo_nx
);

  logic [DW:0] part;
  logic [DW:0] trial;

  // rem < divisor always holds, so {rem, msb} fits in DW+1 bits.
  assign part  = {rem, quo[DW-1]};
  assign trial = part - {1'b0, divisor};

  always_comb begin
    if (!trial[DW]) begin
      rem_nx = trial[DW-1:0];
      quo_nx = {quo[DW-2:0], 1'b1};
    end else begin
      rem_nx = part[DW-1:0];
      quo_nx = {quo[DW-2:0], 1'b0};
    end
  end

endmodule

// File: rtl/div_hilo_seq.sv
// DIV/DIVU sequencer for EX: stalls the pipe while iterating, then writes
// quotient to LO and remainder to HI for one cycle (also driven as bypass).
module div_hilo_seq
  import cpu_defs_pkg::*;
#(
  parameter int DW    = 32,
  parameter int CNT_W = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start_i,
  input  logic          signed_i,
  input  logic [DW-1:0] dividend_i,
  input  logic [DW-1:0] divisor_i,
  input  logic          cancel_i,
  output logic          stallreq_o,
  output logic          busy_o,
  output logic          done_o,
  output logic          div_by_zero_o,
  output logic          hi_we_o,
  output logic          lo_we_o,
  output logic [DW-1:0] hi_o,
  output logic [DW-1:0] lo_o
);

  div_state_e     state, state_nx;
  logic [CNT_W-1:0] cnt;
  logic [DW-1:0]  rem, quo, dsr;
  logic [DW-1:0]  rem_nx, quo_nx;
  logic [DW-1:0]  hi_q, lo_q;
  logic           q_neg, r_neg, dz;
  logic           a_neg, b_neg, accept, last_run, fin;
  logic [DW-1:0]  a_abs, b_abs;
  hilo_bus_t      byp;

  assign a_neg  = signed_i & dividend_i[DW-1];
  assign b_neg  = signed_i & divisor_i[DW-1];
  assign a_abs  = a_neg ? (~dividend_i + DW'(1)) : dividend_i;
  assign b_abs  = b_neg ? (~divisor_i  + DW'(1)) : divisor_i;
  assign accept = (state == IDLE) && start_i && !cancel_i;
  assign last_run = (state == RUN) && (cnt == CNT_W'(DIV_CYCLES - 1));

  div_step #(.DW(DW)) u_step (
    .rem     (rem),
    .quo     (quo),
    .divisor (dsr),
    .rem_nx  (rem_nx),
    .quo_nx  (quo_nx)
  );

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start_i) state_nx = (divisor_i == '0) ? ZERO : RUN;
      RUN:     if (last_run) state_nx = FINISH;
      ZERO:    state_nx = FINISH;
      FINISH:  state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
    if (cancel_i) state_nx = IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      cnt   <= '0;
      rem   <= '0;
      quo   <= '0;
      dsr   <= '0;
      q_neg <= 1'b0;
      r_neg <= 1'b0;
      dz    <= 1'b0;
      hi_q  <= '0;
      lo_q  <= '0;
    end else begin
      state <= state_nx;
      if (accept) begin
        rem   <= '0;
        quo   <= a_abs;
        dsr   <= b_abs;
        q_neg <= a_neg ^ b_neg;
        r_neg <= a_neg;
        dz    <= (divisor_i == '0);
        cnt   <= '0;
      end else if (state == RUN) begin
        rem <= rem_nx;
        quo <= quo_nx;
        cnt <= cnt + CNT_W'(1);
      end
      // Result registers update only on entry to FINISH and hold afterwards.
      if (state_nx == FINISH && state != FINISH) begin
        hi_q <= dz ? '0 : neg_if(r_neg, rem_nx);
        lo_q <= dz ? '0 : neg_if(q_neg, quo_nx);
      end
    end
  end

  assign fin = (state == FINISH) && !cancel_i;

  assign byp.hi_we = fin;
  assign byp.lo_we = fin;
  assign byp.hi    = hi_q;
  assign byp.lo    = lo_q;

  assign hi_we_o       = byp.hi_we;
  assign lo_we_o       = byp.lo_we;
  assign hi_o          = byp.hi;
  assign lo_o          = byp.lo;
  assign done_o        = fin;
  assign div_by_zero_o = fin & dz;
  assign busy_o        = (state != IDLE);
  assign stallreq_o    = !cancel_i &&
                         ((state == RUN) || (state == ZERO) || ((state == IDLE) && start_i));

endmodule

// File: tb/tb_div_hilo_seq.sv
// Directed bench for div_hilo_seq: hand-computed quotient/remainder vectors,
// zero divisor, cancel, reset mid-op and start/cancel corner cases.
module tb_div_hilo_seq;

  logic        clk = 1'b0;
  logic        rst, start_i, signed_i, cancel_i;
  logic [31:0] dividend_i, divisor_i;
  logic        stallreq_o, busy_o, done_o, div_by_zero_o, hi_we_o, lo_we_o;
  logic [31:0] hi_o, lo_o;
  int          checks = 0;
  int          failures = 0;

  div_hilo_seq #(.DW(32), .CNT_W(6)) dut (
    .clk           (clk),
    .rst           (rst),
    .start_i       (start_i),
    .signed_i      (signed_i),
    .dividend_i    (dividend_i),
    .divisor_i     (divisor_i),
    .cancel_i      (cancel_i),
    .stallreq_o    (stallreq_o),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .div_by_zero_o (div_by_zero_o),
    .hi_we_o       (hi_we_o),
    .lo_we_o       (lo_we_o),
    .hi_o          (hi_o),
    .lo_o          (lo_o)
  );

  always #5 clk = ~clk;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Cycle 0 is the current cycle; leaves the bench in cycle 34 (IDLE).
  task automatic run_div(input string tag, input logic sg, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] exp_lo,
                         input logic [31:0] exp_hi, input bit hold);
    start_i = 1'b1; signed_i = sg; dividend_i = a; divisor_i = b;
    #1;
    chk({tag, ".stall_c0"}, stallreq_o, 1);
    cyc();
    for (int c = 1; c <= 32; c++) begin
      start_i = hold;
      if (hold) begin
        dividend_i = $urandom; divisor_i = $urandom; signed_i = ~sg;
      end
      #1;
      if (c == 1 || c == 32) begin
        chk({tag, ".stall_run"}, stallreq_o, 1);
        chk({tag, ".busy_run"}, busy_o, 1);
        chk({tag, ".we_run"}, hi_we_o, 0);
      end
      cyc();
    end
    start_i = 1'b0;
    #1;
    chk({tag, ".done"}, done_o, 1);
    chk({tag, ".hi_we"}, hi_we_o, 1);
    chk({tag, ".lo_we"}, lo_we_o, 1);
    chk({tag, ".dz"}, div_by_zero_o, 0);
    chk({tag, ".stall_fin"}, stallreq_o, 0);
    chk({tag, ".lo"}, lo_o, exp_lo);
    chk({tag, ".hi"}, hi_o, exp_hi);
    cyc();
  endtask

  initial begin
    rst = 1'b1; start_i = 1'b0; signed_i = 1'b0; cancel_i = 1'b0;
    dividend_i = '0; divisor_i = '0;
    cyc(); cyc();
    rst = 1'b0;
    #1;
    chk("rst.busy", busy_o, 0);
    chk("rst.done", done_o, 0);
    chk("rst.stall", stallreq_o, 0);
    chk("rst.hi", hi_o, 0);
    chk("rst.lo", lo_o, 0);
    chk("rst.we", {hi_we_o, lo_we_o, div_by_zero_o}, 0);
    cyc();

    run_div("divu_100_7", 1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 1'b0);
    chk("divu_100_7.busy_after", busy_o, 0);
    chk("divu_100_7.done_after", done_o, 0);
    chk("divu_100_7.hold_lo", lo_o, 32'd14);
    // back-to-back starts from cycle 34
    run_div("div_m7_2", 1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 1'b0);
    run_div("div_7_m2", 1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 1'b0);
    run_div("div_m100_m7", 1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 1'b0);
    run_div("div_ovf", 1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 1'b0);
    run_div("divu_max_1", 1'b0, 32'hFFFFFFFF, 32'd1, 32'hFFFFFFFF, 32'd0, 1'b0);
    run_div("divu_big", 1'b0, 32'hFFFFFFFF, 32'h00010000, 32'h0000FFFF, 32'h0000FFFF, 1'b0);
    run_div("divu_hold", 1'b0, 32'd1000, 32'd33, 32'd30, 32'd10, 1'b1);

    // zero divisor: FINISH at cycle 2, results forced to 0
    start_i = 1'b1; signed_i = 1'b0; dividend_i = 32'd5; divisor_i = 32'd0;
    #1; chk("dz.stall_c0", stallreq_o, 1);
    cyc(); start_i = 1'b0;
    #1; chk("dz.stall_c1", stallreq_o, 1); chk("dz.done_c1", done_o, 0);
    cyc();
    #1;
    chk("dz.done", done_o, 1);
    chk("dz.flag", div_by_zero_o, 1);
    chk("dz.we", {hi_we_o, lo_we_o}, 2'b11);
    chk("dz.hi", hi_o, 0);
    chk("dz.lo", lo_o, 0);
    cyc();
    #1; chk("dz.busy_c3", busy_o, 0); chk("dz.flag_c3", div_by_zero_o, 0);

    // cancel at cycle 10, restart at cycle 12 completes at cycle 45
    start_i = 1'b1; dividend_i = 32'd100; divisor_i = 32'd7;
    cyc(); start_i = 1'b0;
    for (int c = 1; c < 10; c++) cyc();
    cancel_i = 1'b1;
    #1;
    chk("cxl.stall_c10", stallreq_o, 0);
    chk("cxl.we_c10", {hi_we_o, lo_we_o, done_o}, 0);
    cyc(); cancel_i = 1'b0;
    #1;
    chk("cxl.busy_c11", busy_o, 0);
    chk("cxl.we_c11", {hi_we_o, lo_we_o, done_o}, 0);
    cyc();
    run_div("cxl_restart", 1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 1'b0);

    // cancel during FINISH suppresses the write
    start_i = 1'b1; dividend_i = 32'd9; divisor_i = 32'd4;
    cyc(); start_i = 1'b0;
    for (int c = 1; c < 33; c++) cyc();
    cancel_i = 1'b1;
    #1;
    chk("cxf.done", done_o, 0);
    chk("cxf.we", {hi_we_o, lo_we_o}, 0);
    chk("cxf.stall", stallreq_o, 0);
    cyc(); cancel_i = 1'b0;
    #1; chk("cxf.busy", busy_o, 0);
    cyc();

    // reset at cycle 20 of an op
    start_i = 1'b1; dividend_i = 32'd100; divisor_i = 32'd7;
    cyc(); start_i = 1'b0;
    for (int c = 1; c < 20; c++) cyc();
    rst = 1'b1;
    cyc(); rst = 1'b0;
    #1;
    chk("rmid.busy", busy_o, 0);
    chk("rmid.hi", hi_o, 0);
    chk("rmid.lo", lo_o, 0);
    chk("rmid.flags", {done_o, hi_we_o, lo_we_o, div_by_zero_o, stallreq_o}, 0);
    for (int c = 0; c < 16; c++) begin
      cyc();
      if (hi_we_o || lo_we_o) chk("rmid.no_we", {hi_we_o, lo_we_o}, 0);
    end

    // start and cancel together in IDLE
    start_i = 1'b1; cancel_i = 1'b1; dividend_i = 32'd50; divisor_i = 32'd5;
    #1; chk("sc.stall", stallreq_o, 0);
    cyc(); start_i = 1'b0; cancel_i = 1'b0;
    #1; chk("sc.busy", busy_o, 0);
    cyc();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/div_hilo_seq.md
Name: div_hilo_seq

Overview:
- Iterative 32-bit signed/unsigned divider sequencer for the DIV/DIVU instructions in the EX stage.
- Holds a pipeline stall while it iterates, then issues one write of quotient into LO and remainder into HI on the regfile's hi/lo write ports.
- Presents the same result on a bypass bus to the ID-stage hi/lo forwarding path.
- Supports flush (cancel) from the pipeline controller.

Parameters:
- DW, 32, operand/result width.
- CNT_W, 6, iteration counter width (must hold DW).

Ports:
- clk  in  1  system clock; single clock domain.
- rst  in  1  reset, synchronous, active-high.
- start_i  in  1  EX has a DIV/DIVU with valid operands; sampled only in IDLE.
- signed_i  in  1  1=DIV (two's complement), 0=DIVU; sampled with start_i.
- dividend_i  in  DW  rs value; sampled with start_i.
- divisor_i  in  DW  rt value; sampled with start_i.
- cancel_i  in  1  pipeline flush; aborts any operation.
- stallreq_o  out  1  stall request to the pipeline controller.
- busy_o  out  1  operation in progress (state != IDLE).
- done_o  out  1  one-cycle pulse: result valid.
- div_by_zero_o  out  1  one-cycle pulse with done_o when divisor was 0.
- hi_we_o  out  1  HI write enable (regfile w_hi_we and bypass we).
- lo_we_o  out  1  LO write enable.
- hi_o  out  DW  remainder.
- lo_o  out  DW  quotient.

Behaviour:
- Reset: state=IDLE, counter=0, all datapath registers 0. Every output is 0 in the cycle after rst is sampled high. Reset mid-operation discards the operation with no hi/lo write.
- States:
  - IDLE -> RUN on start_i && !cancel_i && divisor_i!=0.
  - IDLE -> ZERO on start_i && !cancel_i && divisor_i==0.
  - RUN -> RUN while counter < DW-1; RUN -> FINISH when counter == DW-1.
  - ZERO -> FINISH.
  - FINISH -> IDLE.
  - cancel_i in any state -> IDLE.
- Latency:
  - Start sampled at cycle 0. RUN occupies cycles 1..32. FINISH is cycle 33; outputs are visible in cycle 33.
  - A zero divisor reaches FINISH at cycle 2.
- Operand prep (at start):
  - Signed mode: latch |dividend| and |divisor| (32-bit wrap, so |0x80000000| = 0x80000000 unsigned). Also latch q_neg = sign(dividend) XOR sign(divisor) and r_neg = sign(dividend).
  - Unsigned mode: q_neg = r_neg = 0.
- RUN iteration (restoring):
  - {rem,quo} <= {rem,quo} << 1.
  - trial = {rem_shifted,dividend_msb} - {1'b0,divisor}, computed at DW+1 bits.
  - If trial is non-negative: rem <= trial[DW-1:0] and quo[0] <= 1.
  - counter increments each RUN cycle.
- FINISH outputs:
  - lo_o = q_neg ? -quo : quo; hi_o = r_neg ? -rem : rem.
  - hi_we_o = lo_we_o = done_o = 1 for exactly one cycle.
  - Zero divisor: lo_o = hi_o = 0 and div_by_zero_o = 1.
- hi_o/lo_o hold their last value after FINISH until the next FINISH. hi_we_o/lo_we_o/done_o are 0 outside FINISH.
- stallreq_o is combinational and equals (state==RUN) || (state==ZERO) || (state==IDLE && start_i && !cancel_i).
  - It is low in FINISH, so the stalled DIV retires in the same cycle hi/lo are written.
  - It is low in any cycle cancel_i=1.
- start_i outside IDLE is ignored; the operands are not resampled.
- cancel_i has priority over everything. In the cycle cancel_i=1, hi_we_o/lo_we_o/done_o are forced 0, including in FINISH. The next state is IDLE.
- start_i and cancel_i high together in IDLE: stay IDLE, no stall.
- Back-to-back: start_i in the cycle after FINISH (state IDLE) starts a new operation normally.

Decomposition:
- Shared package (cpu_defs_pkg, alongside the existing defines header) holds:
  - the state encoding enum: IDLE, RUN, ZERO, FINISH;
  - DIV_CYCLES = 32;
  - the hi/lo bypass bus layout {hi_we, lo_we, hi[31:0], lo[31:0]}, 66 bits, as used by the ex/mem/wb to-ID buses.
- One natural sub-module, div_step: combinational single restoring iteration. Inputs rem, quo, divisor; outputs next rem and next quo. The FSM, counter, sign handling and outputs stay in div_hilo_seq.

Test Plan:
- Unsigned: DIVU 100/7, start at cycle 0 -> stallreq_o high cycles 0..32; cycle 33 lo_o=14, hi_o=2, hi_we_o=lo_we_o=done_o=1; stallreq_o=0.
- Signed: DIV -7/2 (0xFFFFFFF9/0x2) -> cycle 33 lo_o=0xFFFFFFFD, hi_o=0xFFFFFFFF. Also DIV 7/-2 -> lo_o=0xFFFFFFFD, hi_o=1.
- Overflow corner: DIV 0x80000000/0xFFFFFFFF -> lo_o=0x80000000, hi_o=0, no error flag. DIVU 0xFFFFFFFF/1 -> lo_o=0xFFFFFFFF, hi_o=0.
- Zero divisor: DIVU 5/0 -> cycle 2 done_o=1, div_by_zero_o=1, hi_o=lo_o=0; busy_o=0 at cycle 3.
- Cancel: start DIVU 100/7, cancel_i=1 at cycle 10 -> no hi_we_o/lo_we_o pulse ever. stallreq_o=0 in cycle 10, busy_o=0 from cycle 11. A new start at cycle 12 completes correctly at cycle 45. Repeat with cancel_i in FINISH -> we suppressed.
- Robustness: hold start_i high with changing operands during RUN -> result matches the cycle-0 operands. Assert rst at cycle 20 -> all outputs 0 next cycle, no write. Start and cancel together in IDLE -> no stall, state stays IDLE.
